// File: rtl/cell_store.sv
// Write side of the cell cache: places raster-order pixel slices into cell words,
// signals the fetcher once a whole frame is stored, then holds the frame until released.
module cell_store #(
  parameter int CELL_WIDTH     = 768,
  parameter int CELL_ROWS      = 8,
  parameter int CELL_NUM       = 1200,
  parameter int FRAME_ROW_CNUM = 30,
  parameter int FRAME_COL_CNUM = 40,
  localparam int SLICE_W       = CELL_WIDTH / CELL_ROWS,
  localparam int CELL_ADDR_W   = $clog2(CELL_NUM),
  localparam int ROW_ADDR_W    = $clog2(FRAME_ROW_CNUM),
  localparam int COL_ADDR_W    = $clog2(FRAME_COL_CNUM),
  localparam int PROW_W        = $clog2(CELL_ROWS)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [SLICE_W-1:0]     pix_data_i,
  input  logic                   pix_valid_i,
  input  logic                   pix_sof_i,
  output logic                   pix_ready_o,
  output logic                   cell_wr_en_o,
  output logic [CELL_ADDR_W-1:0] cell_wr_addr_o,
  output logic [CELL_WIDTH-1:0]  cell_wr_data_o,
  output logic [CELL_ROWS-1:0]   cell_wr_strb_o,
  output logic                   cell_fetch_start_o,
  input  logic                   frame_release_i,
  output logic                   frame_busy_o,
  output logic                   resync_o
);

  typedef enum logic [1:0] {FILL_ST, NOTIFY_ST, LOCK_ST} state_t;

  state_t                 state;
  logic [COL_ADDR_W-1:0]  cc_cnt;
  logic [PROW_W-1:0]      pr_cnt;
  logic [ROW_ADDR_W-1:0]  cr_cnt;
  logic [CELL_ADDR_W-1:0] base_addr;

  logic                   accept;
  logic                   cnt_nonzero;
  logic                   resync_hit;
  logic [COL_ADDR_W-1:0]  eff_cc;
  logic [PROW_W-1:0]      eff_pr;
  logic [ROW_ADDR_W-1:0]  eff_cr;
  logic [CELL_ADDR_W-1:0] eff_base;
  logic                   cc_last;
  logic                   pr_last;
  logic                   cr_last;
  logic                   frame_last;
  logic [CELL_ROWS-1:0]   strb_next;
  logic [CELL_WIDTH-1:0]  data_next;

  assign pix_ready_o        = (state == FILL_ST);
  assign frame_busy_o       = (state == NOTIFY_ST) || (state == LOCK_ST);
  assign cell_fetch_start_o = (state == NOTIFY_ST);

  assign accept      = pix_valid_i && pix_ready_o;
  assign cnt_nonzero = (cc_cnt != '0) || (pr_cnt != '0) || (cr_cnt != '0);
  assign resync_hit  = accept && pix_sof_i && cnt_nonzero;

  // An SOF beat is always treated as cell 0 / slice 0, whatever the counters say.
  assign eff_cc   = pix_sof_i ? '0 : cc_cnt;
  assign eff_pr   = pix_sof_i ? '0 : pr_cnt;
  assign eff_cr   = pix_sof_i ? '0 : cr_cnt;
  assign eff_base = pix_sof_i ? '0 : base_addr;

  assign cc_last    = (eff_cc == COL_ADDR_W'(FRAME_COL_CNUM - 1));
  assign pr_last    = (eff_pr == PROW_W'(CELL_ROWS - 1));
  assign cr_last    = (eff_cr == ROW_ADDR_W'(FRAME_ROW_CNUM - 1));
  assign frame_last = cc_last && pr_last && cr_last;

  for (genvar gi = 0; gi < CELL_ROWS; gi++) begin : g_slice
    assign strb_next[gi] = (eff_pr == PROW_W'(gi));
    assign data_next[gi*SLICE_W +: SLICE_W] = strb_next[gi] ? pix_data_i : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= FILL_ST;
      cc_cnt         <= '0;
      pr_cnt         <= '0;
      cr_cnt         <= '0;
      base_addr      <= '0;
      cell_wr_en_o   <= 1'b0;
      cell_wr_addr_o <= '0;
      cell_wr_data_o <= '0;
      cell_wr_strb_o <= '0;
      resync_o       <= 1'b0;
    end else begin
      cell_wr_en_o <= accept;
      resync_o     <= resync_hit;

      if (accept) begin
        cell_wr_addr_o <= eff_base + CELL_ADDR_W'(eff_cc);
        cell_wr_data_o <= data_next;
        cell_wr_strb_o <= strb_next;

        if (frame_last) begin
          cc_cnt    <= '0;
          pr_cnt    <= '0;
          cr_cnt    <= '0;
          base_addr <= '0;
        end else if (!cc_last) begin
          cc_cnt    <= eff_cc + 1'b1;
          pr_cnt    <= eff_pr;
          cr_cnt    <= eff_cr;
          base_addr <= eff_base;
        end else if (!pr_last) begin
          cc_cnt    <= '0;
          pr_cnt    <= eff_pr + 1'b1;
          cr_cnt    <= eff_cr;
          base_addr <= eff_base;
        end else begin
          // Cell-row advance: base address steps by one row of cells, no multiplier.
          cc_cnt    <= '0;
          pr_cnt    <= '0;
          cr_cnt    <= eff_cr + 1'b1;
          base_addr <= eff_base + CELL_ADDR_W'(FRAME_COL_CNUM);
        end
      end

      case (state)
        FILL_ST:   if (accept && frame_last) state <= NOTIFY_ST;
        NOTIFY_ST: state <= LOCK_ST;
        LOCK_ST:   if (frame_release_i) state <= FILL_ST;
        default:   state <= FILL_ST;
      endcase
    end
  end

endmodule

// File: tb/tb_cell_store.sv
// Directed bench for cell_store: single-beat placement, row wrap, full frames,
// frame lock/release, mid-frame SOF resync and mid-frame reset.
module tb_cell_store;

  localparam int NCELL  = 1200;
  localparam int NBEATS = 9600;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [95:0]  pix_data = '0;
  logic         pix_valid = 1'b0;
  logic         pix_sof = 1'b0;
  logic         pix_ready;
  logic         wr_en;
  logic [10:0]  wr_addr;
  logic [767:0] wr_data;
  logic [7:0]   wr_strb;
  logic         fetch_start;
  logic         frame_release = 1'b0;
  logic         frame_busy;
  logic         resync;

  int tests = 0;
  int fails = 0;

  cell_store dut (
    .clk                (clk),
    .rst                (rst),
    .pix_data_i         (pix_data),
    .pix_valid_i        (pix_valid),
    .pix_sof_i          (pix_sof),
    .pix_ready_o        (pix_ready),
    .cell_wr_en_o       (wr_en),
    .cell_wr_addr_o     (wr_addr),
    .cell_wr_data_o     (wr_data),
    .cell_wr_strb_o     (wr_strb),
    .cell_fetch_start_o (fetch_start),
    .frame_release_i    (frame_release),
    .frame_busy_o       (frame_busy),
    .resync_o           (resync)
  );

  always #5 clk = ~clk;

  // Write monitor: cumulative counters plus per-cell slice coverage.
  int         wr_cnt = 0, fetch_cnt = 0, fetch_last_cnt = 0, resync_cnt = 0, dup_cnt = 0;
  int         clr_req = 1, clr_seen = 0;
  logic [7:0] cov [NCELL];

  always @(negedge clk) begin
    if (clr_req != clr_seen) begin
      for (int i = 0; i < NCELL; i++) cov[i] = '0;
      clr_seen = clr_req;
    end
    if (wr_en === 1'b1) begin
      wr_cnt++;
      if (int'(wr_addr) < NCELL) begin
        if ((cov[wr_addr] & wr_strb) != 8'h00) dup_cnt++;
        cov[wr_addr] = cov[wr_addr] | wr_strb;
      end else begin
        dup_cnt++;
      end
    end
    if (fetch_start === 1'b1) begin
      fetch_cnt++;
      if (wr_en === 1'b1 && wr_addr == 11'd1199 && wr_strb == 8'h80) fetch_last_cnt++;
    end
    if (resync === 1'b1) resync_cnt++;
  end

  int w0, f0, fl0, d0, r0;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: run still active at %0t, required to finish earlier", $time);
    $fatal(1, "watchdog");
  end

  function automatic logic [95:0] pat(input int i);
    return {32'hC0DE0000 | i, 32'(i * 3), ~32'(i)};
  endfunction

  function automatic logic [767:0] place(input logic [95:0] d, input int pr);
    logic [767:0] r;
    r = '0;
    r[pr*96 +: 96] = d;
    return r;
  endfunction

  task automatic chk(input string tag, input logic [767:0] obs, input logic [767:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present one beat; returns just after the accepting edge with valid dropped.
  task automatic beat(input logic [95:0] d, input logic s);
    int w;
    @(negedge clk);
    pix_valid = 1'b1;
    pix_data  = d;
    pix_sof   = s;
    w = 0;
    while (pix_ready !== 1'b1 && w < 50) begin
      @(negedge clk);
      w++;
    end
    if (w >= 50) chk("ready_timeout", 768'(pix_ready), 768'd1);
    @(posedge clk);
    #1;
    pix_valid = 1'b0;
    pix_sof   = 1'b0;
  endtask

  task automatic run(input int first, input int n, input int gap_pct);
    for (int i = 0; i < n; i++) begin
      if (gap_pct > 0 && $urandom_range(99, 0) < gap_pct) @(negedge clk);
      beat(pat(first + i), 1'b0);
    end
  endtask

  task automatic mark();
    @(negedge clk);
    #1;
    clr_req++;
    w0 = wr_cnt; f0 = fetch_cnt; fl0 = fetch_last_cnt; d0 = dup_cnt; r0 = resync_cnt;
  endtask

  task automatic check_frame(input string tag);
    int bad;
    #1;
    bad = 0;
    for (int i = 0; i < NCELL; i++) if (cov[i] != 8'hFF) bad++;
    chk({tag, "_cov_missing"}, 768'(bad), 768'd0);
    chk({tag, "_wr_count"}, 768'(wr_cnt - w0), 768'(NBEATS));
    chk({tag, "_dup"}, 768'(dup_cnt - d0), 768'd0);
    chk({tag, "_fetch_count"}, 768'(fetch_cnt - f0), 768'd1);
    chk({tag, "_fetch_with_last"}, 768'(fetch_last_cnt - fl0), 768'd1);
  endtask

  task automatic check_last(input string tag, input logic [95:0] d);
    @(negedge clk);
    chk({tag, "_last_en"}, 768'(wr_en), 768'd1);
    chk({tag, "_last_addr"}, 768'(wr_addr), 768'd1199);
    chk({tag, "_last_strb"}, 768'(wr_strb), 768'h80);
    chk({tag, "_last_data"}, wr_data, place(d, 7));
    chk({tag, "_fetch"}, 768'(fetch_start), 768'd1);
    chk({tag, "_busy"}, 768'(frame_busy), 768'd1);
    chk({tag, "_ready"}, 768'(pix_ready), 768'd0);
  endtask

  initial begin
    // Reset with valid held high: rst must win, nothing written.
    rst = 1'b1;
    pix_valid = 1'b1;
    pix_data = pat(999);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_en", 768'(wr_en), 768'd0);
    chk("rst_addr", 768'(wr_addr), 768'd0);
    chk("rst_strb", 768'(wr_strb), 768'd0);
    chk("rst_data", wr_data, 768'd0);
    chk("rst_fetch", 768'(fetch_start), 768'd0);
    chk("rst_resync", 768'(resync), 768'd0);
    chk("rst_busy", 768'(frame_busy), 768'd0);
    chk("rst_ready", 768'(pix_ready), 768'd1);
    chk("rst_no_write", 768'(wr_cnt), 768'd0);
    rst = 1'b0;
    pix_valid = 1'b0;

    // Single beat lands in cell 0, slice 0.
    beat(96'hA5, 1'b0);
    @(negedge clk);
    chk("b1_en", 768'(wr_en), 768'd1);
    chk("b1_addr", 768'(wr_addr), 768'd0);
    chk("b1_strb", 768'(wr_strb), 768'h01);
    chk("b1_data", wr_data, 768'hA5);
    @(negedge clk);
    chk("idle_en", 768'(wr_en), 768'd0);
    chk("idle_addr_held", 768'(wr_addr), 768'd0);

    // Column wrap: beat 40 is cell 39 slice 0, beat 41 is cell 0 slice 1.
    run(2, 38, 0);
    beat(pat(40), 1'b0);
    @(negedge clk);
    chk("b40_addr", 768'(wr_addr), 768'd39);
    chk("b40_strb", 768'(wr_strb), 768'h01);
    beat(pat(41), 1'b0);
    @(negedge clk);
    chk("b41_addr", 768'(wr_addr), 768'd0);
    chk("b41_strb", 768'(wr_strb), 768'h02);
    chk("b41_data", wr_data, place(pat(41), 1));

    // Full frame with random valid gaps.
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    mark();
    run(1, 320, 12);
    beat(pat(321), 1'b0);
    @(negedge clk);
    chk("b321_addr", 768'(wr_addr), 768'd40);
    chk("b321_strb", 768'(wr_strb), 768'h01);
    run(322, NBEATS - 322, 12);
    beat(pat(NBEATS), 1'b0);
    frame_release = 1'b1;  // lands in the notify cycle, must be ignored
    check_last("f1", pat(NBEATS));
    @(posedge clk);
    #1;
    frame_release = 1'b0;
    @(negedge clk);
    chk("f1_fetch_one_cycle", 768'(fetch_start), 768'd0);
    chk("f1_lock_busy", 768'(frame_busy), 768'd1);
    chk("f1_lock_ready", 768'(pix_ready), 768'd0);
    check_frame("f1");

    // Locked: valid held high, nothing accepted until release.
    pix_valid = 1'b1;
    pix_data  = pat(7777);
    repeat (4) begin
      @(negedge clk);
      chk("lock_ready", 768'(pix_ready), 768'd0);
      chk("lock_en", 768'(wr_en), 768'd0);
      chk("lock_busy", 768'(frame_busy), 768'd1);
    end
    frame_release = 1'b1;
    @(posedge clk);
    #1;
    frame_release = 1'b0;
    @(negedge clk);
    chk("rel_ready", 768'(pix_ready), 768'd1);
    chk("rel_busy", 768'(frame_busy), 768'd0);
    chk("rel_no_write_yet", 768'(wr_en), 768'd0);
    @(posedge clk);
    #1;
    pix_valid = 1'b0;
    @(negedge clk);
    chk("rel_beat_en", 768'(wr_en), 768'd1);
    chk("rel_beat_addr", 768'(wr_addr), 768'd0);
    chk("rel_beat_strb", 768'(wr_strb), 768'h01);
    chk("rel_beat_data", wr_data, place(pat(7777), 0));

    // Mid-frame SOF on beat 500 restarts the frame.
    run(2, 498, 0);
    mark();
    beat(pat(500), 1'b1);
    @(negedge clk);
    chk("sof_resync", 768'(resync), 768'd1);
    chk("sof_en", 768'(wr_en), 768'd1);
    chk("sof_addr", 768'(wr_addr), 768'd0);
    chk("sof_strb", 768'(wr_strb), 768'h01);
    @(negedge clk);
    chk("sof_resync_one_cycle", 768'(resync), 768'd0);
    run(501, NBEATS - 2, 5);
    beat(pat(20000), 1'b0);
    check_last("f2", pat(20000));
    check_frame("f2");
    chk("f2_resync_count", 768'(resync_cnt - r0), 768'd1);
    @(negedge clk);
    frame_release = 1'b1;
    @(posedge clk);
    #1;
    frame_release = 1'b0;

    // SOF on the first beat is normal; then reset after beat 5000.
    beat(pat(1), 1'b1);
    @(negedge clk);
    chk("sof0_resync", 768'(resync), 768'd0);
    chk("sof0_addr", 768'(wr_addr), 768'd0);
    run(2, 4999, 0);
    mark();
    @(negedge clk);
    rst = 1'b1;
    pix_valid = 1'b1;
    pix_data = pat(5001);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("mrst_en", 768'(wr_en), 768'd0);
    rst = 1'b0;
    pix_valid = 1'b0;
    @(negedge clk);
    #1;
    chk("mrst_no_write", 768'(wr_cnt - w0), 768'd0);
    chk("mrst_no_fetch", 768'(fetch_cnt - f0), 768'd0);
    chk("mrst_busy", 768'(frame_busy), 768'd0);
    mark();
    beat(pat(1), 1'b0);
    @(negedge clk);
    chk("mrst_first_addr", 768'(wr_addr), 768'd0);
    chk("mrst_first_strb", 768'(wr_strb), 768'h01);
    run(2, NBEATS - 2, 5);
    beat(pat(NBEATS), 1'b0);
    check_last("f3", pat(NBEATS));
    check_frame("f3");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
